pic_pc_sequencer: RTL and testbench

- Instruction-cycle controller for the PIC16C57 core.
- Generates the four-phase Q1..Q4 cycle and owns the 11-bit program counter and the 2-level hardware return stack.
- Runs the two-stage fetch/execute pipeline: it fetches from program ROM, latches the instruction register that feeds the decoder, and flushes the prefetched word on GOTO, CALL, RETLW, PCL writes and taken skips.
- Sits between program ROM, the decoder and the datapath/register file.

---
 rtl/pic_pc_sequencer.sv | 140 ++++++++++++++
 tb/tb_pic_pc_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pic_pc_sequencer.sv
// pic_pc_sequencer: PIC16C57 Q1..Q4 cycle generator, program counter,
// two-level return stack and two-stage fetch/execute pipeline.
module pic_pc_sequencer #(
    parameter logic [10:0] RESET_VECTOR = 11'h7FF,
    parameter logic [11:0] NOP_WORD     = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [11:0] instr_in,
    output logic [10:0] pc_out,
    output logic [11:0] ir,
    output logic        exec_valid,
    output logic [1:0]  phase,
    input  logic [5:0]  operation,
    input  logic [8:0]  literal,
    input  logic [1:0]  pa,
    input  logic        alu_zero,
    input  logic        bit_val,
    input  logic        pcl_we,
    input  logic [7:0]  pcl_wdata,
    output logic        stack_ovf,
    output logic        stack_unf
);

    localparam logic [5:0] OP_DECFSZ = 6'd6;
    localparam logic [5:0] OP_INCFSZ = 6'd9;
    localparam logic [5:0] OP_BTFSC  = 6'd20;
    localparam logic [5:0] OP_BTFSS  = 6'd21;
    localparam logic [5:0] OP_CALL   = 6'd23;
    localparam logic [5:0] OP_RETLW  = 6'd24;
    localparam logic [5:0] OP_GOTO   = 6'd25;

    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } phase_t;

    phase_t      r_phase;
    logic [10:0] r_pc;
    logic [11:0] r_ir;
    logic        r_exec_valid;
    logic [10:0] r_stk0;
    logic [10:0] r_stk1;
    logic [1:0]  r_depth;
    logic        r_ovf;
    logic        r_unf;

    logic        w_commit;
    logic        w_skip;
    logic [10:0] w_pc_inc;
    logic [10:0] w_next_pc;
    logic        w_flush;
    logic        w_push;
    logic        w_pop;

    assign w_commit = run && (r_phase == Q4);
    assign w_pc_inc = r_pc + 11'd1;

    assign w_skip = ((operation == OP_DECFSZ) && alu_zero)
                 || ((operation == OP_INCFSZ) && alu_zero)
                 || ((operation == OP_BTFSC)  && !bit_val)
                 || ((operation == OP_BTFSS)  && bit_val);

    // A flushed ir is a NOP: no branch, no stack, no skip.
    always_comb begin
        w_next_pc = w_pc_inc;
        w_flush   = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        if (r_exec_valid) begin
            if (operation == OP_GOTO) begin
                w_next_pc = {pa, literal};
                w_flush   = 1'b1;
            end else if (operation == OP_CALL) begin
                w_next_pc = {pa, 1'b0, literal[7:0]};
                w_flush   = 1'b1;
                w_push    = 1'b1;
            end else if (operation == OP_RETLW) begin
                w_next_pc = r_stk0;
                w_flush   = 1'b1;
                w_pop     = 1'b1;
            end else if (pcl_we) begin
                w_next_pc = {pa, 1'b0, pcl_wdata};
                w_flush   = 1'b1;
            end else if (w_skip) begin
                w_flush   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= Q1;
            r_pc         <= RESET_VECTOR;
            r_ir         <= NOP_WORD;
            r_exec_valid <= 1'b0;
            r_stk0       <= 11'd0;
            r_stk1       <= 11'd0;
            r_depth      <= 2'd0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
        end else if (run) begin
            r_phase <= phase_t'(r_phase + 2'd1);
            if (w_commit) begin
                r_ir         <= instr_in;
                r_exec_valid <= !w_flush;
                r_pc         <= w_next_pc;
                if (w_push) begin
                    r_stk1 <= r_stk0;
                    r_stk0 <= r_pc;
                    if (r_depth == 2'd2) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_depth <= r_depth + 2'd1;
                    end
                end
                // Underflow still hands back stk0 as the return address.
                if (w_pop) begin
                    r_stk0 <= r_stk1;
                    if (r_depth == 2'd0) begin
                        r_unf <= 1'b1;
                    end else begin
                        r_depth <= r_depth - 2'd1;
                    end
                end
            end
        end
    end

    assign pc_out     = r_pc;
    assign ir         = r_ir;
    assign exec_valid = r_exec_valid;
    assign phase      = r_phase;
    assign stack_ovf  = r_ovf;
    assign stack_unf  = r_unf;

endmodule

// File: tb/tb_pic_pc_sequencer.sv
// tb_pic_pc_sequencer: directed checks of Q-cycle, PC flow, stack and
// pipeline flush; ROM word at address A is {1'b1, A}.
module tb_pic_pc_sequencer;

    localparam logic [5:0] OP_NOP    = 6'd0;
    localparam logic [5:0] OP_DECFSZ = 6'd6;
    localparam logic [5:0] OP_INCFSZ = 6'd9;
    localparam logic [5:0] OP_BTFSC  = 6'd20;
    localparam logic [5:0] OP_BTFSS  = 6'd21;
    localparam logic [5:0] OP_CALL   = 6'd23;
    localparam logic [5:0] OP_RETLW  = 6'd24;
    localparam logic [5:0] OP_GOTO   = 6'd25;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [11:0] instr_in;
    logic [10:0] pc_out;
    logic [11:0] ir;
    logic        exec_valid;
    logic [1:0]  phase;
    logic [5:0]  operation;
    logic [8:0]  literal;
    logic [1:0]  pa;
    logic        alu_zero;
    logic        bit_val;
    logic        pcl_we;
    logic [7:0]  pcl_wdata;
    logic        stack_ovf;
    logic        stack_unf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign instr_in = {1'b1, pc_out};

    pic_pc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .instr_in   (instr_in),
        .pc_out     (pc_out),
        .ir         (ir),
        .exec_valid (exec_valid),
        .phase      (phase),
        .operation  (operation),
        .literal    (literal),
        .pa         (pa),
        .alu_zero   (alu_zero),
        .bit_val    (bit_val),
        .pcl_we     (pcl_we),
        .pcl_wdata  (pcl_wdata),
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf)
    );

    task automatic chk(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One instruction cycle from Q1 (at a negedge) to the next Q1.
    // Q1..Q3 carry 'noise' on the Q4-only inputs.
    task automatic icycle(input logic [5:0] op, input logic [8:0] lit,
                          input logic [1:0] p, input logic az,
                          input logic bv, input logic we,
                          input logic [7:0] wd, input logic noise);
        operation = op;
        literal   = lit;
        pa        = p;
        alu_zero  = noise;
        bit_val   = noise;
        pcl_we    = noise;
        pcl_wdata = 8'h3C;
        repeat (3) @(negedge clk);
        chk("phase_q4", 12'(phase), 12'd3);
        alu_zero  = az;
        bit_val   = bv;
        pcl_we    = we;
        pcl_wdata = wd;
        @(negedge clk);
        alu_zero  = 1'b0;
        bit_val   = 1'b0;
        pcl_we    = 1'b0;
    endtask

    task automatic step(input logic [5:0] op, input logic [8:0] lit,
                        input logic [1:0] p);
        icycle(op, lit, p, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Jump to addr and let the flushed slot pass: addr is now executing.
    task automatic land(input logic [10:0] addr);
        step(OP_GOTO, addr[8:0], addr[10:9]);
        step(OP_NOP, 9'h000, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        operation = OP_NOP;
        literal = 9'h000;
        pa = 2'b00;
        alu_zero = 1'b0;
        bit_val = 1'b0;
        pcl_we = 1'b0;
        pcl_wdata = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_phase", 12'(phase), 12'd0);
        chk("rst_pc", 12'(pc_out), 12'h7FF);
        chk("rst_ir", ir, 12'h000);
        chk("rst_ev", 12'(exec_valid), 12'd0);
        chk("rst_ovf", 12'(stack_ovf), 12'd0);
        chk("rst_unf", 12'(stack_unf), 12'd0);
        rst_n = 1'b1;
        run = 1'b1;

        step(OP_NOP, 9'h000, 2'b00);
        chk("c1_pc_wrap", 12'(pc_out), 12'h000);
        chk("c1_ir", ir, 12'hFFF);
        step(OP_NOP, 9'h000, 2'b00);
        chk("c2_pc", 12'(pc_out), 12'h001);
        chk("c2_ev", 12'(exec_valid), 12'd1);
        chk("c2_ir", ir, 12'h800);

        step(OP_GOTO, 9'h1A5, 2'b10);
        chk("goto_pc", 12'(pc_out), 12'h5A5);
        chk("goto_ev", 12'(exec_valid), 12'd0);
        step(OP_GOTO, 9'h1A5, 2'b10);
        chk("flushed_pc", 12'(pc_out), 12'h5A6);
        chk("flushed_ev", 12'(exec_valid), 12'd1);
        chk("target_ir", ir, 12'hDA5);

        land(11'h010);
        chk("land10_pc", 12'(pc_out), 12'h011);
        step(OP_CALL, 9'h040, 2'b00);
        chk("call_pc", 12'(pc_out), 12'h040);
        chk("call_ev", 12'(exec_valid), 12'd0);
        step(OP_NOP, 9'h000, 2'b00);
        step(OP_RETLW, 9'h000, 2'b00);
        chk("ret_pc", 12'(pc_out), 12'h011);
        chk("ret_ev", 12'(exec_valid), 12'd0);
        chk("ret_ovf", 12'(stack_ovf), 12'd0);
        chk("ret_unf", 12'(stack_unf), 12'd0);
        step(OP_NOP, 9'h000, 2'b00);

        land(11'h100);
        step(OP_CALL, 9'h155, 2'b00);
        chk("call1_pc", 12'(pc_out), 12'h055);
        step(OP_NOP, 9'h000, 2'b00);
        land(11'h200);
        step(OP_CALL, 9'h155, 2'b00);
        chk("call2_ovf", 12'(stack_ovf), 12'd0);
        step(OP_NOP, 9'h000, 2'b00);
        land(11'h300);
        step(OP_CALL, 9'h155, 2'b00);
        chk("call3_ovf", 12'(stack_ovf), 12'd1);
        step(OP_NOP, 9'h000, 2'b00);
        step(OP_RETLW, 9'h000, 2'b00);
        chk("pop1_pc", 12'(pc_out), 12'h301);
        chk("pop1_unf", 12'(stack_unf), 12'd0);
        step(OP_NOP, 9'h000, 2'b00);
        step(OP_RETLW, 9'h000, 2'b00);
        chk("pop2_pc", 12'(pc_out), 12'h201);
        chk("pop2_unf", 12'(stack_unf), 12'd0);
        step(OP_NOP, 9'h000, 2'b00);
        step(OP_RETLW, 9'h000, 2'b00);
        chk("pop3_pc", 12'(pc_out), 12'h201);
        chk("pop3_unf", 12'(stack_unf), 12'd1);
        step(OP_NOP, 9'h000, 2'b00);

        land(11'h020);
        icycle(OP_DECFSZ, 9'h000, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("decfsz_pc", 12'(pc_out), 12'h022);
        chk("decfsz_ev", 12'(exec_valid), 12'd0);
        chk("decfsz_ir", ir, 12'h821);
        step(OP_NOP, 9'h000, 2'b00);
        icycle(OP_DECFSZ, 9'h000, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("decfsz_q2_pc", 12'(pc_out), 12'h024);
        chk("decfsz_q2_ev", 12'(exec_valid), 12'd1);
        icycle(OP_BTFSC, 9'h000, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("btfsc_pc", 12'(pc_out), 12'h025);
        chk("btfsc_ev", 12'(exec_valid), 12'd0);
        step(OP_NOP, 9'h000, 2'b00);
        icycle(OP_BTFSS, 9'h000, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("btfss_pc", 12'(pc_out), 12'h027);
        chk("btfss_ev", 12'(exec_valid), 12'd1);
        icycle(OP_INCFSZ, 9'h000, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("incfsz_ev", 12'(exec_valid), 12'd0);
        step(OP_NOP, 9'h000, 2'b00);
        chk("incfsz_pc", 12'(pc_out), 12'h029);

        icycle(OP_NOP, 9'h000, 2'b01, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        chk("pcl_pc", 12'(pc_out), 12'h2FF);
        chk("pcl_ev", 12'(exec_valid), 12'd0);
        chk("pcl_ir", ir, 12'h829);

        run = 1'b0;
        repeat (5) @(negedge clk);
        chk("frz_phase", 12'(phase), 12'd0);
        chk("frz_pc", 12'(pc_out), 12'h2FF);
        chk("frz_ir", ir, 12'h829);
        run = 1'b1;
        repeat (2) @(negedge clk);
        chk("q3_phase", 12'(phase), 12'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_phase", 12'(phase), 12'd0);
        chk("arst_pc", 12'(pc_out), 12'h7FF);
        chk("arst_ir", ir, 12'h000);
        chk("arst_ev", 12'(exec_valid), 12'd0);
        chk("arst_ovf", 12'(stack_ovf), 12'd0);
        chk("arst_unf", 12'(stack_unf), 12'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
